// File: rtl/sa_mul_resp_pkg.sv
// Shared types for the SA multiply responder: response payload and widths.
// The package tag width is the default TAG_W of sa_mul_resp.
package sa_mul_resp_pkg;

    localparam int SA_W      = 32;
    localparam int PKG_TAG_W = 8;

    typedef struct packed {
        logic [PKG_TAG_W-1:0] tag;
        logic [SA_W-1:0]      result;
        logic                 exception;
        logic                 overflow;
        logic                 underflow;
    } sa_rsp_t;

endpackage

// File: rtl/sa_mul.sv
// SA IEEE-754 single multiplier, combinational, round-to-nearest-even.
// Denormal inputs count as zero; an exponent of all ones raises Exception.
module sa_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);

    logic              sign;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [47:0]       prod;
    logic [47:0]       nrm;
    logic              rnd;
    logic [23:0]       mant_r;
    logic signed [9:0] exp_s;
    logic              zero;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        nrm    = prod[47] ? prod : (prod << 1);
        rnd    = nrm[23] & ((|nrm[22:0]) | nrm[24]);
        mant_r = {1'b0, nrm[46:24]} + {23'd0, rnd};
        // A rounding carry leaves the mantissa zero and bumps the exponent.
        exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb})
               - 10'sd127
               + $signed({9'd0, prod[47]})
               + $signed({9'd0, mant_r[23]});

        exception = (&ea) | (&eb);
        zero      = !exception && (ea == 8'd0 || eb == 8'd0);
        overflow  = !exception && !zero && (exp_s >= 10'sd255);
        underflow = !exception && !zero && (exp_s <= 10'sd0);

        result = {sign, exp_s[7:0], mant_r[22:0]};
        if (exception)
            result = 32'h0000_0000;
        else if (zero || underflow)
            result = {sign, 31'd0};
        else if (overflow)
            result = {sign, 8'hFF, 23'd0};
    end

endmodule

// File: rtl/sa_resp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH (power of two).
module sa_resp_fifo
    import sa_mul_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  sa_rsp_t push_data,
    input  logic    pop,
    output sa_rsp_t head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    sa_rsp_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sa_mul_resp.sv
// SA multiply responder: S1 operand register, SA, credit-limited response FIFO.
// Define SA_RESP_STATS_EN to enable the saturating flag counters.
module sa_mul_resp
    import sa_mul_resp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      stat_exc,
    output logic [15:0]      stat_ovf,
    output logic [15:0]      stat_unf
);

    localparam int IW = $clog2(DEPTH) + 1;

    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic [IW-1:0]    inflight;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    sa_rsp_t          push_data;
    sa_rsp_t          head;

    // Credits cover S1 plus every FIFO slot, so a push never meets a full FIFO.
    assign req_ready = rst_n && (inflight < IW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rst_n && !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
            inflight <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= req_a;
                s1_b   <= req_b;
                s1_tag <= req_tag;
            end
            if (accept && !pop)
                inflight <= inflight + IW'(1);
            else if (pop && !accept)
                inflight <= inflight - IW'(1);
        end
    end

    sa_mul u_sa (
        .a         (s1_a),
        .b         (s1_b),
        .result    (push_data.result),
        .exception (push_data.exception),
        .overflow  (push_data.overflow),
        .underflow (push_data.underflow)
    );

    assign push_data.tag = PKG_TAG_W'(s1_tag);

    sa_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid && !fifo_full),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_result    = rsp_valid ? head.result : '0;
    assign rsp_exception = rsp_valid && head.exception;
    assign rsp_overflow  = rsp_valid && head.overflow;
    assign rsp_underflow = rsp_valid && head.underflow;
    assign rsp_tag       = rsp_valid ? TAG_W'(head.tag) : '0;

`ifdef SA_RESP_STATS_EN
    logic [15:0] exc_cnt;
    logic [15:0] ovf_cnt;
    logic [15:0] unf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_cnt <= '0;
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (pop) begin
            if (head.exception && exc_cnt != 16'hFFFF)
                exc_cnt <= exc_cnt + 16'd1;
            if (head.overflow && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
            if (head.underflow && unf_cnt != 16'hFFFF)
                unf_cnt <= unf_cnt + 16'd1;
        end
    end

    assign stat_exc = exc_cnt;
    assign stat_ovf = ovf_cnt;
    assign stat_unf = unf_cnt;
`else
    assign stat_exc = 16'h0000;
    assign stat_ovf = 16'h0000;
    assign stat_unf = 16'h0000;
`endif

endmodule
